fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
Downstream consumer of the single-port-RAM sync FIFO read port. The FIFO has a 1-cycle read latency: dout is valid only in the cycle after rd_en && !empty. This block converts that port into a first-word-fall-through valid/ready stream. It uses a 2-entry output buffer and in-flight read tracking to sustain 1 word/cycle under continuous m_ready.

Parameters:
DW, 16, data width; must match the FIFO DW.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO read request; asserted only when fifo_empty=0
fifo_dout  input  DW  FIFO read data; valid the cycle after fifo_rd_en
clr  input  1  synchronous flush of buffered and in-flight data
m_valid  output  1  stream data valid
m_ready  input  1  stream sink ready
m_data  output  DW  stream data, always the head entry
occ  output  2  buffered entries, 0..2 (in-flight read not counted)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. On reset, every register clears: occ=0, m_valid=0, m_data=0, fifo_rd_en=0, inflight=0, rd/wr slot pointers=0.
- Storage: 2-entry register buffer, indexed by a 1-bit write slot pointer and a 1-bit read slot pointer. Both pointers wrap modulo 2.
- pop = m_valid && m_ready.
- m_valid = (occ != 0). m_data = buf[rd_slot]. Both are registered-state-driven, with no combinational path from m_ready.
- inflight: 1-bit register, set to fifo_rd_en on every cycle. When inflight=1, fifo_dout is written to buf[wr_slot] and wr_slot increments. This capture is mandatory and occurs in that exact cycle. The RAM's rdata can change on later RAM accesses, so data must never be sampled late.
- Issue rule: fifo_rd_en = !fifo_empty && !clr && (occ + inflight - pop) < 2. This guarantees that a returning word always has a free slot.
- Throughput: with m_ready held high and the FIFO non-empty, the steady state is occ=1, inflight=1, with one pop and one read per cycle.
- Latency: first m_valid appears 2 cycles after fifo_empty deasserts. Cycle 0: rd issued. Cycle 1: capture. Cycle 2: m_valid=1.
- Occupancy update: occ_next = occ + inflight - pop, computed with a 2-bit width. Capture and pop in the same cycle leave occ unchanged.
- Backpressure: while m_ready=0, occ fills to 2 and then fifo_rd_en stays low. m_data and m_valid must stay stable while m_valid=1 and m_ready=0.
- clr, cycle N: occ, rd_slot, wr_slot and inflight are cleared at the next edge. fifo_rd_en=0 in cycle N. A read issued in cycle N-1 returns in cycle N and is discarded. Any pop in cycle N is ignored internally: the FIFO word is lost by design, and the sink must not rely on a handshake during clr. m_valid=0 from cycle N+1.
- fifo_empty asserting while inflight=1: the in-flight word is still captured, and no further reads are issued.
- Reset mid-stream: all state clears immediately. The FIFO is reset by the same rst_n, so there is no orphan read.
- Invariant, asserted in simulation: occ + inflight <= 2. A capture with occ=2 and no pop is an error.

Decomposition:
- No shared package needed; only the constant BUF_DEPTH=2 is local to the module.
- One natural sub-module: stream_skid_buf2. It holds the 2-entry buffer, slot pointers and occ, with a push/pop interface. The top level holds the issue logic and the inflight register.

Test Plan:
- Single word: FIFO holds 0xA5A5, m_ready=1 → fifo_rd_en pulses once, m_valid=1 with m_data=0xA5A5 two cycles later for exactly 1 cycle, occ returns to 0.
- Streaming: FIFO holds 0x0001..0x0008, m_ready=1 → 8 consecutive m_valid cycles, data in order, no bubbles after the first.
- Backpressure: 4 words, m_ready=0 for 6 cycles, then 1 → occ saturates at 2, fifo_rd_en=0 while occ+inflight=2, data held stable, all 4 words delivered in order.
- Alternating m_ready (1,0,1,0...) with 8 words → every word delivered exactly once, in order; the occ+inflight<=2 assertion never fires.
- clr the cycle after a read issue with occ=1 → next cycle m_valid=0, occ=0, in-flight word dropped; subsequent words resume correctly.
- rst_n pulsed low mid-stream, asynchronously between edges → outputs go to 0 immediately; after release, a fresh fill of 0x1111 is delivered correctly.

Source files
------------

// File: rtl/stream_skid_buf2.sv
// Two-entry register buffer with 1-bit wrapping slot pointers and an occupancy count.
// The head entry is always presented on data; valid is derived from occupancy alone.
module stream_skid_buf2 #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic [1:0]    occ
);
   localparam int BUF_DEPTH = 2;

   logic [DW-1:0] buf_reg [BUF_DEPTH];
   logic          wr_slot_reg;
   logic          rd_slot_reg;
   logic [1:0]    occ_reg;
   logic [1:0]    occ_next;

   // Push and pop in the same cycle cancel, leaving occupancy unchanged.
   always_comb begin
      occ_next = occ_reg + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_reg     <= 2'd0;
         wr_slot_reg <= 1'b0;
         rd_slot_reg <= 1'b0;
      end else if (clr) begin
         occ_reg     <= 2'd0;
         wr_slot_reg <= 1'b0;
         rd_slot_reg <= 1'b0;
      end else begin
         occ_reg <= occ_next;
         if (push) wr_slot_reg <= ~wr_slot_reg;
         if (pop)  rd_slot_reg <= ~rd_slot_reg;
      end
   end

   for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            buf_reg[gi] <= '0;
         end else if (push && !clr && (wr_slot_reg == 1'(gi))) begin
            buf_reg[gi] <= push_data;
         end
      end
   end

   assign valid = (occ_reg != 2'd0);
   assign data  = buf_reg[rd_slot_reg];
   assign occ   = occ_reg;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a first-word-fall-through valid/ready stream.
// Reads are only issued when the returning word is guaranteed a free buffer slot.
module fifo_rd_stream_adapter #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fifo_empty,
   output logic          fifo_rd_en,
   input  logic [DW-1:0] fifo_dout,
   input  logic          clr,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [1:0]    occ
);
   logic       inflight_reg;
   logic       pop;
   logic       buf_push;
   logic       buf_pop;
   logic [1:0] level_after;

   assign pop = m_valid && m_ready;

   // Occupancy once this cycle's capture and pop land; occ + inflight never exceeds 2.
   assign level_after = occ + {1'b0, inflight_reg} - {1'b0, pop};

   // Gated by rst_n so no request leaves while the block is held in reset.
   assign fifo_rd_en = rst_n && !fifo_empty && !clr && (level_after < 2'd2);

   // A flush discards the returning word and ignores any handshake in that cycle.
   assign buf_push = inflight_reg && !clr;
   assign buf_pop  = pop && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= fifo_rd_en;
      end
   end

   stream_skid_buf2 #(
      .DW(DW)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (buf_push),
      .push_data (fifo_dout),
      .pop       (buf_pop),
      .valid     (m_valid),
      .data      (m_data),
      .occ       (occ)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, occ} + {2'b00, inflight_reg}) <= 3'd2);

   a_capture_has_room: assert property (@(posedge clk) disable iff (!rst_n)
      (inflight_reg && !clr && (occ == 2'd2)) |-> pop);

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench: queue-based FIFO with 1-cycle read latency feeding the adapter, checked each cycle
// against a queue model of buffered/in-flight words plus hand-computed directed expectations.
module tb_fifo_rd_stream_adapter;
   localparam int DW = 16;

   logic          clk;
   logic          rst_n;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_dout;
   logic          clr;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [1:0]    occ;

   fifo_rd_stream_adapter #(.DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .clr        (clr),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .occ        (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] fq[$];      // words held by the upstream FIFO
   logic [DW-1:0] outq[$];    // model: words buffered in the adapter
   logic [DW-1:0] deliv[$];   // model: words handed to the sink
   bit            pend_v;
   logic [DW-1:0] pend_d;

   int cyc = 0;
   int first_valid;
   int last_valid;
   int nvalid;
   int max_occ;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      first_valid = -1;
      last_valid  = -1;
      nvalid      = 0;
      max_occ     = 0;
      deliv.delete();
   endtask

   // One clock cycle: drive inputs, compare against the model, advance model and FIFO.
   task automatic step(input bit rdy, input bit c);
      bit exp_pop;
      bit exp_rd;
      bit rd;
      int lvl;
      m_ready    = rdy;
      clr        = c;
      fifo_empty = (fq.size() == 0);
      #1;
      exp_pop = (outq.size() != 0) && rdy;
      lvl     = outq.size() + int'(pend_v) - int'(exp_pop);
      exp_rd  = !fifo_empty && !c && (lvl < 2);
      chk("m_valid", m_valid, outq.size() != 0);
      chk("occ", occ, outq.size());
      if (outq.size() != 0) chk("m_data", m_data, outq[0]);
      chk("fifo_rd_en", fifo_rd_en, exp_rd);
      if (m_valid) begin
         if (first_valid < 0) first_valid = cyc;
         last_valid = cyc;
         nvalid++;
      end
      if (int'(occ) > max_occ) max_occ = int'(occ);
      if (c) begin
         outq.delete();
      end else begin
         if (exp_pop) deliv.push_back(outq.pop_front());
         if (pend_v) outq.push_back(pend_d);
      end
      pend_v = exp_rd;
      if (exp_rd) pend_d = fq[0];
      rd = fifo_rd_en;
      @(posedge clk);
      #1;
      cyc++;
      if (rd && fq.size() > 0) fifo_dout = fq.pop_front();
      else fifo_dout = 16'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int errs;
      bit done;
      rst_n      = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      clr        = 1'b0;
      m_ready    = 1'b0;
      pend_v     = 1'b0;
      pend_d     = '0;
      clear_stats();
      #12;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_occ", occ, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_fifo_rd_en", fifo_rd_en, 0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word
      clear_stats();
      fq.push_back(16'hA5A5);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      chk("single_latency", first_valid - (cyc - 6), 2);
      chk("single_nvalid", nvalid, 1);
      chk("single_count", deliv.size(), 1);
      if (deliv.size() > 0) chk("single_data", deliv[0], 16'hA5A5);
      chk("single_occ_end", occ, 0);

      // Streaming
      clear_stats();
      for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
      chk("stream_span", last_valid - first_valid, 7);
      chk("stream_nvalid", nvalid, 8);
      errs = 0;
      for (int i = 0; i < deliv.size(); i++) if (deliv[i] !== 16'(i + 1)) errs++;
      chk("stream_count", deliv.size(), 8);
      chk("stream_order", errs, 0);

      // Backpressure
      clear_stats();
      for (int i = 0; i < 4; i++) fq.push_back(16'(16'h40 + i));
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      chk("bp_occ_full", occ, 2);
      chk("bp_rd_held", fifo_rd_en, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      chk("bp_max_occ", max_occ, 2);
      errs = 0;
      for (int i = 0; i < deliv.size(); i++) if (deliv[i] !== 16'(16'h40 + i)) errs++;
      chk("bp_count", deliv.size(), 4);
      chk("bp_order", errs, 0);

      // Alternating ready
      clear_stats();
      for (int i = 0; i < 8; i++) fq.push_back(16'(16'h70 + i));
      for (int i = 0; i < 24; i++) step(i[0] == 1'b0, 1'b0);
      errs = 0;
      for (int i = 0; i < deliv.size(); i++) if (deliv[i] !== 16'(16'h70 + i)) errs++;
      chk("alt_count", deliv.size(), 8);
      chk("alt_order", errs, 0);

      // Flush while one word is buffered and one is in flight
      clear_stats();
      fq.push_back(16'hB001);
      fq.push_back(16'hB002);
      fq.push_back(16'hB003);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("clr_pre_occ", occ, 1);
      step(1'b0, 1'b1);
      chk("clr_m_valid", m_valid, 0);
      chk("clr_occ", occ, 0);
      fq.push_back(16'hC001);
      fq.push_back(16'hC002);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      chk("clr_count", deliv.size(), 3);
      if (deliv.size() == 3) begin
         chk("clr_w0", deliv[0], 16'hB003);
         chk("clr_w1", deliv[1], 16'hC001);
         chk("clr_w2", deliv[2], 16'hC002);
      end

      // Asynchronous reset mid-stream
      for (int i = 0; i < 6; i++) fq.push_back(16'(16'hD0 + i));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      #2 rst_n = 1'b0;
      fq.delete();
      outq.delete();
      pend_v     = 1'b0;
      fifo_empty = 1'b1;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_occ", occ, 0);
      chk("arst_m_data", m_data, 0);
      chk("arst_fifo_rd_en", fifo_rd_en, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_stats();
      fq.push_back(16'h1111);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      chk("arst_refill_count", deliv.size(), 1);
      if (deliv.size() > 0) chk("arst_refill_data", deliv[0], 16'h1111);

      // Randomized traffic
      clear_stats();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) fq.push_back(16'($urandom));
         step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 29) == 0);
      end
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         done = (fq.size() == 0) && (outq.size() == 0) && !pend_v;
         if (!done) step(1'b1, 1'b0);
      end
      chk("drain_done", done, 1);
      chk("drain_occ", occ, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
